seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receiver for the multiplexed 7-segment interface driven by the display block: watches the active-low `seg`/`an` pair and rebuilds the 4-digit frame.
- Outputs per-digit raw segment patterns, decoded hex nibbles, a frame-valid pulse and a change flag.
- Used as an on-chip self-check of the display path and as a scoreboard front-end in system benches.

Parameters:
- SETTLE, 4: consecutive cycles a digit select must hold before its segments are sampled (ghosting filter); legal range ≥1.
- TIMEOUT, 2000000: cycles without any digit capture before the frame is declared stale; legal range ≥16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg  in  8  segment lines, active-low; seg[7]=dp, seg[6:0]=g..a
- an  in  4  digit enables, active-low; an[0]=rightmost digit
- digits  out  32  captured raw patterns; digits[8i+7:8i] = digit i
- hex  out  16  decoded nibble per digit; hex[4i+3:4i] = digit i
- hex_ok  out  4  bit i = digit i matched the hex table
- frame_valid  out  1  one-cycle pulse when a complete frame is latched
- frame_changed  out  1  one-cycle pulse coincident with frame_valid when digits differs from the previous frame
- stale  out  1  no capture for TIMEOUT cycles
- err_an  out  1  sticky illegal-select flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync-free release): all outputs 0; internal slots 0; got mask 0; counters 0; previous-frame register 0.
- Input stage: seg and an are registered once (seg_r, an_r) and all logic uses the registered copies. Pins-to-capture latency = 1 + SETTLE cycles.
- Select classification: exactly one zero in an_r → active digit idx. an_r=4'hF → blank. Any other pattern → illegal, treated as blank.
- Dwell counter:
  - Resets to 0 when an_r changes or is blank/illegal; otherwise increments, saturating at SETTLE.
  - Capture happens once per dwell, in the cycle the counter reaches SETTLE-1: slot[idx] <= seg_r, got[idx] <= 1.
  - A digit re-captured before the frame completes overwrites its slot.
- Frame completion: in the cycle after got becomes 4'hF:
  - digits <= slots; hex/hex_ok <= decode(slots); frame_valid=1.
  - frame_changed=1 iff the new digits != the previous latched digits.
  - got <= 0; stale <= 0.
  - A capture arriving in that same cycle sets its got bit after the clear.
- Hex decode uses seg[6:0] only (dp ignored). Table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - A pattern not in the table gives nibble 0 and hex_ok bit 0.
- Timeout counter:
  - Cleared on every capture; increments otherwise; saturates at TIMEOUT.
  - On reaching TIMEOUT: stale <= 1 and got <= 0. Partial frames are discarded; digits/hex hold their last values.
- Mid-operation async reset discards partial frames; no frame_valid is emitted on release.
- All outputs are registered.

Optional Feature:
- Macro: SEGDEC_ONEHOT_CHECK_EN.
- Defined:
  - err_an sets on any cycle where an_r has two or more zero bits; it is sticky until reset.
  - That cycle also clears got, so a frame straddling a corrupt select is never emitted.
- Undefined: err_an is tied 0; illegal selects are treated as blank and got is untouched.

Decomposition:
- Shared package `seg_pkg` holds:
  - the 16-entry active-low hex pattern constants;
  - the digit count (4) and segment width (8) localparams;
  - a decode function. The display block uses the same constants for encoding.
- One natural sub-module, `seg_hex_lut`: combinational 7-bit pattern → {ok, nibble}, instantiated four times at frame latch.

Test Plan:
- Reset values: hold rst_n=0 with random seg/an → all outputs 0. Release and apply an=4'hF for 100 cycles → no frame_valid, stale=0.
- Normal frame: scan an=E,D,B,7 with seg=F9,A4,B0,99, each for 8 cycles (SETTLE=4) → one frame_valid, hex=16'h4321, hex_ok=4'hF, digits=32'h99B0A4F9, frame_changed=1. Repeat the same scan → frame_valid=1, frame_changed=0.
- Ghosting: per digit, apply the correct seg for only the first 2 dwell cycles, then garbage 0xFF. Separately, apply dwell=3 with SETTLE=4 → no capture, no frame_valid.
- Unknown pattern: digit 2 shows seg=0x7F → hex[11:8]=0, hex_ok=4'b1011. dp variant 0x79 vs 0xF9 → both decode as 1.
- Timeout: with TIMEOUT=64, capture digits 0–2, then hold an=4'hF for 64 cycles → stale=1 and the partial frame is dropped. A full scan then gives frame_valid and stale=0.
- With SEGDEC_ONEHOT_CHECK_EN: inject an=4'hC for 1 cycle mid-frame → err_an=1 (sticky) and no frame_valid until a full new scan. Without the macro, err_an stays 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment constants and hex decode, common to the display encoder and the scan decoder.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 8;

  // Active-low g..a patterns for 0..F; dp is not part of the table.
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [4:0] hex_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (pat == HEX_PAT[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational 7-bit segment pattern to {ok, nibble}; unknown patterns give ok=0, nibble=0.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nib_o,
  output logic       ok_o
);

  assign {ok_o, nib_o} = hex_decode(pat_i);

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 4-digit frame from the multiplexed active-low seg/an interface.
// Optional strict one-hot select checking is enabled with SEGDEC_ONEHOT_CHECK_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEG_W-1:0]              seg,
  input  logic [NUM_DIGITS-1:0]         an,
  output logic [NUM_DIGITS*SEG_W-1:0]   digits,
  output logic [NUM_DIGITS*4-1:0]       hex,
  output logic [NUM_DIGITS-1:0]         hex_ok,
  output logic                          frame_valid,
  output logic                          frame_changed,
  output logic                          stale,
  output logic                          err_an
);

  localparam int unsigned DW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [SEG_W-1:0]            seg_q;
  logic [NUM_DIGITS-1:0]       an_q, an_prev_q;
  logic [DW-1:0]               dwell_q, dwell_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [NUM_DIGITS*SEG_W-1:0] slots_q, slots_d;
  logic [NUM_DIGITS-1:0]       got_q, got_d;
  logic [NUM_DIGITS*SEG_W-1:0] digits_q, digits_d;
  logic [NUM_DIGITS*4-1:0]     hex_q, hex_d;
  logic [NUM_DIGITS-1:0]       hex_ok_q, hex_ok_d;
  logic                        fv_q, fv_d, fc_q, fc_d;
  logic                        stale_q, stale_d, err_q, err_d;

  logic                        sel_valid_s, capture_s, frame_done_s, tmo_hit_s, sel_clr_s;
  logic [1:0]                  sel_idx_s;
  logic [NUM_DIGITS*4-1:0]     lut_nib_s;
  logic [NUM_DIGITS-1:0]       lut_ok_s;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    seg_hex_lut u_lut (
      .pat_i (slots_q[g*SEG_W +: 7]),
      .nib_o (lut_nib_s[g*4 +: 4]),
      .ok_o  (lut_ok_s[g])
    );
  end

  // Select classification: exactly one low enable names the active digit.
  always_comb begin
    sel_valid_s = 1'b1;
    sel_idx_s   = 2'd0;
    case (an_q)
      4'hE:    sel_idx_s = 2'd0;
      4'hD:    sel_idx_s = 2'd1;
      4'hB:    sel_idx_s = 2'd2;
      4'h7:    sel_idx_s = 2'd3;
      default: sel_valid_s = 1'b0;
    endcase
  end

`ifdef SEGDEC_ONEHOT_CHECK_EN
  assign sel_clr_s = (an_q != 4'hF) && !sel_valid_s;
  assign err_d     = err_q | sel_clr_s;
`else
  assign sel_clr_s = 1'b0;
  assign err_d     = 1'b0;
`endif

  always_comb begin
    dwell_d      = dwell_q;
    tmo_d        = tmo_q;
    slots_d      = slots_q;
    got_d        = got_q;
    digits_d     = digits_q;
    hex_d        = hex_q;
    hex_ok_d     = hex_ok_q;
    fv_d         = 1'b0;
    fc_d         = 1'b0;
    stale_d      = stale_q;

    if (!sel_valid_s || (an_q != an_prev_q)) begin
      dwell_d = '0;
    end else if (dwell_q != DW'(SETTLE)) begin
      dwell_d = dwell_q + DW'(1);
    end else begin
      dwell_d = dwell_q;
    end
    // The counter passes SETTLE-1 exactly once per dwell, so this fires once.
    capture_s = sel_valid_s && (dwell_d == DW'(SETTLE - 1));

    if (capture_s) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
    tmo_hit_s    = !capture_s && (tmo_d == TW'(TIMEOUT));
    frame_done_s = (got_q == 4'hF);

    if (frame_done_s) begin
      digits_d = slots_q;
      hex_d    = lut_nib_s;
      hex_ok_d = lut_ok_s;
      fv_d     = 1'b1;
      fc_d     = (slots_q != digits_q);
      stale_d  = 1'b0;
    end else if (tmo_hit_s) begin
      stale_d  = 1'b1;
    end else begin
      stale_d  = stale_q;
    end

    if (frame_done_s || tmo_hit_s || sel_clr_s) begin
      got_d = '0;
    end else begin
      got_d = got_q;
    end
    // A capture in the completion cycle survives the clear above.
    if (capture_s) begin
      slots_d[{sel_idx_s, 3'b000} +: 8] = seg_q;
      got_d[sel_idx_s]                  = 1'b1;
    end else begin
      slots_d = slots_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      an_q      <= '0;
      an_prev_q <= '0;
      dwell_q   <= '0;
      tmo_q     <= '0;
      slots_q   <= '0;
      got_q     <= '0;
      digits_q  <= '0;
      hex_q     <= '0;
      hex_ok_q  <= '0;
      fv_q      <= 1'b0;
      fc_q      <= 1'b0;
      stale_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      seg_q     <= seg;
      an_q      <= an;
      an_prev_q <= an_q;
      dwell_q   <= dwell_d;
      tmo_q     <= tmo_d;
      slots_q   <= slots_d;
      got_q     <= got_d;
      digits_q  <= digits_d;
      hex_q     <= hex_d;
      hex_ok_q  <= hex_ok_d;
      fv_q      <= fv_d;
      fc_q      <= fc_d;
      stale_q   <= stale_d;
      err_q     <= err_d;
    end
  end

  assign digits        = digits_q;
  assign hex           = hex_q;
  assign hex_ok        = hex_ok_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign stale         = stale_q;
  assign err_an        = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (SETTLE=4, TIMEOUT=64).
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [3:0]  an = 4'hF;
  logic [31:0] digits;
  logic [15:0] hex;
  logic [3:0]  hex_ok;
  logic        frame_valid, frame_changed, stale, err_an;

  int total = 0;
  int bad = 0;
  int fv_total = 0;
  int stray_fc = 0;
  logic last_fc = 1'b0;

  seg_scan_decoder #(.SETTLE(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .digits(digits), .hex(hex), .hex_ok(hex_ok),
    .frame_valid(frame_valid), .frame_changed(frame_changed),
    .stale(stale), .err_an(err_an)
  );

  always #5 clk = ~clk;

  // Frame pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_total = fv_total + 1;
      last_fc  = frame_changed;
    end
    if (frame_changed && !frame_valid) stray_fc = stray_fc + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    seg = s;
    step(n);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    hold(4'hE, s0, 8);
    hold(4'hD, s1, 8);
    hold(4'hB, s2, 8);
    hold(4'h7, s3, 8);
    hold(4'hF, 8'hFF, 4);
  endtask

  task automatic test_reset;
    int base;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      an = 4'($urandom);
      seg = 8'($urandom);
      step(1);
    end
    total++; if (digits !== 32'h0) begin bad++; $display("FAIL reset_digits got=%h want=0", digits); end
    total++; if (hex !== 16'h0 || hex_ok !== 4'h0) begin bad++; $display("FAIL reset_hex got=%h/%h want=0/0", hex, hex_ok); end
    total++; if ({frame_valid, frame_changed, stale, err_an} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b want=0000", {frame_valid, frame_changed, stale, err_an}); end
    base = fv_total;
    rst_n = 1'b1;
    hold(4'hF, 8'hFF, 40);
    total++; if (fv_total - base !== 0) begin bad++; $display("FAIL blank_no_frame got=%0d want=0", fv_total - base); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL blank_stale got=%b want=0", stale); end
  endtask

  task automatic test_normal;
    int base;
    base = fv_total;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL normal_count got=%0d want=1", fv_total - base); end
    total++; if (hex !== 16'h4321) begin bad++; $display("FAIL normal_hex got=%h want=4321", hex); end
    total++; if (hex_ok !== 4'hF) begin bad++; $display("FAIL normal_ok got=%h want=f", hex_ok); end
    total++; if (digits !== 32'h99B0A4F9) begin bad++; $display("FAIL normal_digits got=%h want=99b0a4f9", digits); end
    total++; if (last_fc !== 1'b1) begin bad++; $display("FAIL normal_changed got=%b want=1", last_fc); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL normal_stale got=%b want=0", stale); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = fv_total;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL repeat_count got=%0d want=1", fv_total - base); end
    total++; if (last_fc !== 1'b0) begin bad++; $display("FAIL repeat_changed got=%b want=0", last_fc); end
  endtask

  task automatic test_ghost;
    int base;
    logic [3:0] sel [4];
    logic [7:0] good [4];
    sel = '{4'hE, 4'hD, 4'hB, 4'h7};
    good = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    base = fv_total;
    for (int d = 0; d < 4; d++) begin
      hold(sel[d], good[d], 2);
      hold(sel[d], 8'hFF, 6);
    end
    hold(4'hF, 8'hFF, 4);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL ghost_count got=%0d want=1", fv_total - base); end
    total++; if (digits !== 32'hFFFFFFFF) begin bad++; $display("FAIL ghost_digits got=%h want=ffffffff", digits); end
    total++; if (hex_ok !== 4'h0 || hex !== 16'h0) begin bad++; $display("FAIL ghost_hex got=%h/%h want=0/0", hex, hex_ok); end
    base = fv_total;
    for (int d = 0; d < 4; d++) hold(sel[d], good[d], 3);
    hold(4'hF, 8'hFF, 6);
    total++; if (fv_total - base !== 0) begin bad++; $display("FAIL short_dwell got=%0d want=0", fv_total - base); end
    total++; if (digits !== 32'hFFFFFFFF) begin bad++; $display("FAIL short_dwell_hold got=%h want=ffffffff", digits); end
  endtask

  task automatic test_unknown;
    int base;
    base = fv_total;
    scan(8'h79, 8'hA4, 8'h7F, 8'h99);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL unk_count got=%0d want=1", fv_total - base); end
    total++; if (hex !== 16'h4021) begin bad++; $display("FAIL unk_hex got=%h want=4021", hex); end
    total++; if (hex_ok !== 4'b1011) begin bad++; $display("FAIL unk_ok got=%b want=1011", hex_ok); end
    total++; if (digits !== 32'h997FA479) begin bad++; $display("FAIL unk_digits got=%h want=997fa479", digits); end
  endtask

  task automatic test_timeout;
    int base;
    base = fv_total;
    hold(4'hE, 8'hF9, 8);
    hold(4'hD, 8'hA4, 8);
    hold(4'hB, 8'hB0, 8);
    hold(4'hF, 8'hFF, 80);
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL tmo_stale got=%b want=1", stale); end
    total++; if (digits !== 32'h997FA479) begin bad++; $display("FAIL tmo_digits_hold got=%h want=997fa479", digits); end
    hold(4'h7, 8'h99, 8);
    hold(4'hF, 8'hFF, 4);
    total++; if (fv_total - base !== 0) begin bad++; $display("FAIL tmo_partial_dropped got=%0d want=0", fv_total - base); end
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL tmo_recover got=%0d want=1", fv_total - base); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL tmo_stale_clear got=%b want=0", stale); end
    total++; if (last_fc !== 1'b1 || hex !== 16'h4321) begin bad++; $display("FAIL tmo_frame got=%b/%h want=1/4321", last_fc, hex); end
  endtask

  task automatic test_onehot;
    int base;
    int exp_n;
    logic exp_err;
`ifdef SEGDEC_ONEHOT_CHECK_EN
    exp_n = 0; exp_err = 1'b1;
`else
    exp_n = 1; exp_err = 1'b0;
`endif
    base = fv_total;
    hold(4'hE, 8'hF9, 8);
    hold(4'hD, 8'hA4, 8);
    hold(4'hC, 8'hFF, 1);
    hold(4'hB, 8'hB0, 8);
    hold(4'h7, 8'h99, 8);
    hold(4'hF, 8'hFF, 4);
    total++; if (err_an !== exp_err) begin bad++; $display("FAIL onehot_err got=%b want=%b", err_an, exp_err); end
    total++; if (fv_total - base !== exp_n) begin bad++; $display("FAIL onehot_frame got=%0d want=%0d", fv_total - base, exp_n); end
    base = fv_total;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    total++; if (fv_total - base !== 1) begin bad++; $display("FAIL onehot_rescan got=%0d want=1", fv_total - base); end
    total++; if (err_an !== exp_err) begin bad++; $display("FAIL onehot_sticky got=%b want=%b", err_an, exp_err); end
  endtask

  task automatic test_midreset;
    int base;
    base = fv_total;
    hold(4'hE, 8'hF9, 8);
    hold(4'hD, 8'hA4, 8);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    total++; if (digits !== 32'h0 || err_an !== 1'b0) begin bad++; $display("FAIL midrst_clear got=%h/%b want=0/0", digits, err_an); end
    hold(4'hB, 8'hB0, 8);
    hold(4'h7, 8'h99, 8);
    hold(4'hF, 8'hFF, 4);
    total++; if (fv_total - base !== 0) begin bad++; $display("FAIL midrst_partial got=%0d want=0", fv_total - base); end
    total++; if (stray_fc !== 0) begin bad++; $display("FAIL changed_without_valid got=%0d want=0", stray_fc); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_back_to_back;
    test_ghost;
    test_unknown;
    test_timeout;
    test_onehot;
    test_midreset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
